// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern_tx_011 serial frame transmitter.
//   state_e    : transmitter FSM states
//   MARKER     : frame-start preamble, sent left to right (0,1,1)
//   MARKER_LEN : number of preamble bits
//   max3       : helper for sizing the shared bit counter
//   marker_bit : preamble bit for a given position within the preamble
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic [2:0]  MARKER     = 3'b011;
  localparam int unsigned MARKER_LEN = 3;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Position 0 is the first bit on the line, i.e. the MSB of MARKER.
  function automatic logic marker_bit(input logic [1:0] pos);
    logic b;
    case (pos)
      2'd0:    b = MARKER[2];
      2'd1:    b = MARKER[1];
      default: b = MARKER[0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pattern_tx_011_piso_shreg.sv
// Parallel-in / serial-out shift register, MSB first.
// Ports:
//   clk   : rising-edge clock
//   nrst  : synchronous active-low reset, register returns to all-ones
//   load  : capture din (has priority over shift)
//   shift : move one place toward the MSB, filling the LSB with 1
//   din   : parallel load value
//   sout  : serial tap, always the current MSB
module piso_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] q;

  // Shift fills with ones so an exhausted register reads as an idle line.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      q <= '1;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= (q << 1) | W'(1);
    end
  end

  assign sout = q[W-1];

endmodule

// File: rtl/pattern_tx_011.sv
// Serial frame transmitter feeding the downstream "011" sequence detector.
// A word accepted over load_valid/load_ready is sent MSB first on x, one bit
// per clock, optionally preceded by a 0,1,1 preamble, and followed by GAP_CYC
// idle cycles. The line idles at 1.
// Build option: define PATTERN_TX_MARKER_EN to prefix every frame with the
// preamble; when undefined the frame carries the payload only.
// Ports:
//   clk        : rising-edge clock
//   nrst       : synchronous active-low reset
//   load_valid : load_data is presented
//   load_ready : word can be accepted (high only in IDLE)
//   load_data  : payload word, captured on handshake
//   x          : serial line, 1 when idle
//   x_valid    : x carries a preamble or payload bit
//   frame_done : one-cycle pulse with the last payload bit
module pattern_tx_011
  import pattern_tx_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              x,
  output logic              x_valid,
  output logic              frame_done
);

  localparam int unsigned CNT_MAX = max3(DATA_W, GAP_CYC, MARKER_LEN);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
`ifdef PATTERN_TX_MARKER_EN
  localparam logic [CNT_W-1:0] MARK_LAST = CNT_W'(MARKER_LEN - 1);
  localparam state_e           FIRST_ST  = MARK;
`else
  localparam state_e           FIRST_ST  = DATA;
`endif

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic              x_d;
  logic              x_valid_d;
  logic              frame_done_d;
  logic              load_ready_d;

  logic              sh_load_c;
  logic              sh_shift_c;
  logic [DATA_W-1:0] sh_din_c;
  logic              sh_out;

  piso_shreg #(
    .W (DATA_W)
  ) u_shreg (
    .clk   (clk),
    .nrst  (nrst),
    .load  (sh_load_c),
    .shift (sh_shift_c),
    .din   (sh_din_c),
    .sout  (sh_out)
  );

  // State and bit-counter register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and bit counter; the counter restarts on every state entry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (load_valid) begin
          state_nx = FIRST_ST;
        end
      end
`ifdef PATTERN_TX_MARKER_EN
      MARK: begin
        if (cnt == MARK_LAST) begin
          state_nx = DATA;
          cnt_nx   = '0;
        end
      end
`endif
      DATA: begin
        if (cnt == DATA_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from where the FSM is going,
  // so every output can be registered without adding a cycle of latency.
  always_comb begin
    x_d          = 1'b1;
    x_valid_d    = 1'b0;
    frame_done_d = 1'b0;
    load_ready_d = 1'b0;
    sh_load_c    = (state == IDLE) && load_valid;
    sh_shift_c   = 1'b0;
`ifdef PATTERN_TX_MARKER_EN
    sh_din_c     = load_data;
`else
    // The MSB goes straight to the line at capture, so store the word
    // already advanced by one place.
    sh_din_c     = (load_data << 1) | DATA_W'(1);
`endif
    case (state_nx)
      IDLE: begin
        load_ready_d = 1'b1;
      end
`ifdef PATTERN_TX_MARKER_EN
      MARK: begin
        x_d       = marker_bit(2'(cnt_nx));
        x_valid_d = 1'b1;
      end
`endif
      DATA: begin
        x_valid_d    = 1'b1;
        frame_done_d = (cnt_nx == DATA_LAST);
        if (state == IDLE) begin
          x_d = load_data[DATA_W-1];
        end else begin
          x_d        = sh_out;
          sh_shift_c = 1'b1;
        end
      end
      default: begin
        x_d = 1'b1;
      end
    endcase
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      x          <= 1'b1;
      x_valid    <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      x          <= x_d;
      x_valid    <= x_valid_d;
      frame_done <= frame_done_d;
      load_ready <= load_ready_d;
    end
  end

endmodule
